// File: rtl/edge_update_queue_pkg.sv
// forex_pkg: shared edge type, register map and sequencer states for the edge update path.
package forex_pkg;
  localparam int PRED_W   = 4;
  localparam int WEIGHT_W = 31;
  typedef struct packed {
    logic [PRED_W:0]   src;
    logic [PRED_W:0]   dst;
    logic [WEIGHT_W:0] weight;
  } edge_t;
  localparam logic [2:0] ADDR_STAGE   = 3'd0;
  localparam logic [2:0] ADDR_PUSH    = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CLR_OVF = 3'd3;
  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_DONE} state_e;
endpackage

// File: rtl/edge_update_queue_if.sv
// edge_update_queue_if: Avalon-MM host slave plus the downstream edge/done handshake.
interface edge_update_queue_if #(
  parameter int PRED_WIDTH   = 4,
  parameter int WEIGHT_WIDTH = 31
);
  logic                    chipselect;
  logic                    write;
  logic                    read;
  logic [2:0]              address;
  logic [WEIGHT_WIDTH:0]   writedata;
  logic [31:0]             readdata;
  logic                    upd_valid;
  logic                    upd_ready;
  logic [PRED_WIDTH:0]     upd_src;
  logic [PRED_WIDTH:0]     upd_dst;
  logic [WEIGHT_WIDTH:0]   upd_weight;
  logic                    core_done;
  modport master (
    output chipselect, write, read, address, writedata, upd_ready, core_done,
    input  readdata, upd_valid, upd_src, upd_dst, upd_weight
  );
  modport slave (
    input  chipselect, write, read, address, writedata, upd_ready, core_done,
    output readdata, upd_valid, upd_src, upd_dst, upd_weight
  );
endinterface

// File: rtl/edge_update_queue_fifo.sv
// edge_fifo: synchronous FIFO of edge entries with occupancy count and full/empty flags.
module edge_fifo import forex_pkg::*; #(
  parameter type T          = edge_t,
  parameter int  DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_push,
  input  logic                i_pop,
  input  T                    i_data,
  output logic                o_full,
  output logic                o_empty,
  output logic [DEPTH_LOG2:0] o_count,
  output T                    o_head
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  T                      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;
  assign o_full  = r_count == (DEPTH_LOG2+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  // Storage has no reset so it maps onto MLAB; the consumer registers the head.
  assign o_head  = r_mem[r_rd_ptr];
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
    end
  end
endmodule

// File: rtl/edge_update_queue.sv
// edge_update_queue: buffers host-written edges and releases one per core recomputation.
module edge_update_queue import forex_pkg::*; #(
  parameter int PRED_WIDTH   = PRED_W,
  parameter int WEIGHT_WIDTH = WEIGHT_W,
  parameter int DEPTH_LOG2   = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  edge_update_queue_if.slave  bus
);
  typedef struct packed {
    logic [PRED_WIDTH:0]   src;
    logic [PRED_WIDTH:0]   dst;
    logic [WEIGHT_WIDTH:0] weight;
  } entry_t;
  logic [PRED_WIDTH:0] r_src;
  logic [PRED_WIDTH:0] r_dst;
  logic                r_ovf;
  state_e              r_state;
  entry_t              r_out;
  logic [31:0]         r_rdata;
  logic                w_wr;
  logic                w_rd;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [DEPTH_LOG2:0] w_count;
  entry_t              w_head;
  entry_t              w_entry;
  logic [31:0]         w_status;
  state_e              w_next;
  assign w_wr     = bus.chipselect && bus.write;
  assign w_rd     = bus.chipselect && bus.read;
  assign w_push   = w_wr && bus.address == ADDR_PUSH;
  assign w_pop    = r_state == IDLE && !w_empty;
  assign w_entry  = '{src: r_src, dst: r_dst, weight: bus.writedata};
  assign w_status = {21'd0, r_state == WAIT_DONE, r_state == PRESENT, r_ovf, 8'(w_count)};
  // core_done outside WAIT_DONE falls through to the hold branch and is ignored.
  assign w_next   = (r_state == IDLE && !w_empty)           ? PRESENT   :
                    (r_state == PRESENT && bus.upd_ready)   ? WAIT_DONE :
                    (r_state == WAIT_DONE && bus.core_done) ? IDLE      : r_state;
  edge_fifo #(.T(entry_t), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_ovf   <= 1'b0;
      r_state <= IDLE;
      r_out   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wr && bus.address == ADDR_STAGE) begin
        r_src <= bus.writedata[2*PRED_WIDTH+1:PRED_WIDTH+1];
        r_dst <= bus.writedata[PRED_WIDTH:0];
      end
      if (w_wr && bus.address == ADDR_CLR_OVF) r_ovf <= 1'b0;
      else if (w_push && w_full) r_ovf <= 1'b1;
      if (w_rd) r_rdata <= bus.address == ADDR_STATUS ? w_status : '0;
      if (w_pop) r_out <= w_head;
      r_state <= w_next;
    end
  end
  assign bus.upd_valid  = r_state == PRESENT;
  assign bus.upd_src    = r_out.src;
  assign bus.upd_dst    = r_out.dst;
  assign bus.upd_weight = r_out.weight;
  assign bus.readdata   = r_rdata;
endmodule

// File: tb/tb_edge_update_queue.sv
// tb_edge_update_queue: random edges checked every cycle against a queue-based reference model.
module tb_edge_update_queue;
  import forex_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  edge_update_queue_if bus ();
  edge_update_queue dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  int          vectors = 0;
  int          errs = 0;
  edge_t       q[$];
  edge_t       cur;
  bit          pres, busy, ovf, g_rdy;
  logic [4:0]  s_src, s_dst;
  logic [31:0] exp_rd;
  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask
  task automatic model_reset();
    q.delete();
    pres = 0; busy = 0; ovf = 0;
    s_src = '0; s_dst = '0; exp_rd = '0;
  endtask
  // One clock of stimulus; the model advances on what was true during the cycle.
  task automatic step(bit cs, bit w, bit r, logic [2:0] a, logic [31:0] d, bit dn);
    logic [31:0] st;
    bit do_pop, full0, hs, dv;
    edge_t e;
    bus.chipselect = cs; bus.write = w; bus.read = r; bus.address = a;
    bus.writedata = d; bus.upd_ready = g_rdy; bus.core_done = dn;
    st = {21'd0, busy, pres, ovf, 8'(q.size())};
    if (cs && r) exp_rd = (a == ADDR_STATUS) ? st : 32'd0;
    do_pop = !pres && !busy && q.size() != 0;
    full0 = q.size() == 16;
    hs = pres && g_rdy;
    dv = busy && dn;
    e = '{src: s_src, dst: s_dst, weight: d};
    @(posedge clk); #1;
    if (cs && w && a == ADDR_STAGE) begin s_src = d[9:5]; s_dst = d[4:0]; end
    if (cs && w && a == ADDR_CLR_OVF) ovf = 0;
    if (cs && w && a == ADDR_PUSH) begin
      if (full0) ovf = 1;
      else q.push_back(e);
    end
    if (do_pop) begin cur = q.pop_front(); pres = 1; end
    if (hs) begin pres = 0; busy = 1; end
    if (dv) busy = 0;
    chk("upd_valid", 32'(bus.upd_valid), 32'(pres));
    if (pres) begin
      chk("upd_src", 32'(bus.upd_src), 32'(cur.src));
      chk("upd_dst", 32'(bus.upd_dst), 32'(cur.dst));
      chk("upd_weight", bus.upd_weight, cur.weight);
    end
    chk("readdata", bus.readdata, exp_rd);
  endtask
  task automatic wr(logic [2:0] a, logic [31:0] d); step(1, 1, 0, a, d, 0); endtask
  task automatic rd(); step(1, 0, 1, ADDR_STATUS, 32'd0, 0); endtask
  task automatic idle(int n); for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 32'd0, 0); endtask
  task automatic done(); step(0, 0, 0, 3'd0, 32'd0, 1); endtask
  task automatic stage_rand(); wr(ADDR_STAGE, $urandom & 32'h3FF); endtask
  task automatic push(logic [31:0] w); wr(ADDR_PUSH, w); endtask
  task automatic drain();
    for (int i = 0; i < 400 && (q.size() != 0 || pres || busy); i++) begin
      g_rdy = 1;
      step(0, 0, 0, 3'd0, 32'd0, busy);
    end
    g_rdy = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.chipselect = 0; bus.write = 0; bus.read = 0; bus.address = '0;
    bus.writedata = '0; bus.upd_ready = 0; bus.core_done = 0;
    g_rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.upd_valid), 32'd0);
    chk("rst_rdata", bus.readdata, 32'd0);
    chk("rst_src", 32'(bus.upd_src), 32'd0);
    chk("rst_weight", bus.upd_weight, 32'd0);
    reset_n = 1;
    // single edge: valid exactly two cycles after the push
    wr(ADDR_STAGE, 32'h21);
    g_rdy = 1;
    push(32'h100);
    chk("single_n1_valid", 32'(bus.upd_valid), 32'd0);
    idle(1);
    chk("single_n2_valid", 32'(bus.upd_valid), 32'd1);
    chk("single_src", 32'(bus.upd_src), 32'd1);
    chk("single_dst", 32'(bus.upd_dst), 32'd1);
    chk("single_weight", bus.upd_weight, 32'h100);
    idle(1);
    chk("single_pulse_end", 32'(bus.upd_valid), 32'd0);
    rd();
    chk("single_wait_status", bus.readdata, 32'h400);
    g_rdy = 0;
    done();
    idle(3);
    rd();
    chk("single_idle_status", bus.readdata, 32'h000);
    // back-pressure: fields held while downstream stalls
    stage_rand(); push($urandom);
    stage_rand(); push($urandom);
    push($urandom);
    idle(10);
    rd();
    chk("bp_status", bus.readdata, 32'h202);
    drain();
    // overflow with the output register already occupied
    stage_rand(); push($urandom);
    idle(1);
    for (int i = 0; i < 17; i++) begin
      if (i % 5 == 0) stage_rand();
      push($urandom);
    end
    rd();
    chk("ovf_status", bus.readdata, 32'h310);
    wr(ADDR_CLR_OVF, $urandom);
    rd();
    chk("ovf_cleared", bus.readdata, 32'h210);
    drain();
    // push and pop in the same cycle at count 5
    g_rdy = 1;
    stage_rand(); push($urandom);
    idle(2);
    g_rdy = 0;
    for (int i = 0; i < 5; i++) push($urandom);
    done();
    push($urandom);
    rd();
    chk("pushpop5_status", bus.readdata, 32'h205);
    drain();
    // push at count 16 during a pop is rejected
    g_rdy = 1;
    stage_rand(); push($urandom);
    idle(2);
    g_rdy = 0;
    for (int i = 0; i < 16; i++) push($urandom);
    done();
    push($urandom);
    rd();
    chk("full_pop_status", bus.readdata, 32'h30F);
    wr(ADDR_CLR_OVF, 32'd0);
    drain();
    // pointer wrap-around: weights 0..39 in order
    for (int i = 0; i < 40; i++) begin
      stage_rand();
      push(32'(i));
      if (i % 8 == 7 || $urandom_range(0, 3) == 0) drain();
    end
    drain();
    rd();
    chk("wrap_status", bus.readdata, 32'h000);
    // asynchronous reset while presenting with four queued
    stage_rand();
    for (int i = 0; i < 5; i++) push($urandom);
    idle(2);
    rd();
    chk("pre_rst_status", bus.readdata, 32'h204);
    idle(1);
    #2;
    reset_n = 0;
    #1;
    chk("midrst_valid", 32'(bus.upd_valid), 32'd0);
    chk("midrst_rdata", bus.readdata, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    rd();
    chk("post_rst_status", bus.readdata, 32'h000);
    idle(10);
    chk("post_rst_quiet", 32'(bus.upd_valid), 32'd0);
    stage_rand(); push($urandom);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
